// File: rtl/gesture_key_conditioner_if.sv
// gesture_key_conditioner_if
//   Bundles the player keys and the conditioned event outputs of the
//   rock-paper-scissors input stage.
//   master : drives the raw keys and observes the events (board or bench side)
//   slave  : the conditioner, which takes the keys and drives the events
// Signals:
//   key_1/2/3     raw active-low keys (scissors, cloth, stone)
//   rx_data_1/2/3 active-low event pulses, idle high
//   choice        last accepted key code (00 none, 01/10/11 = key_1/2/3)
//   choice_valid  one-cycle strobe in the cycle choice updates
interface gesture_key_conditioner_if;
  logic       key_1;
  logic       key_2;
  logic       key_3;
  logic       rx_data_1;
  logic       rx_data_2;
  logic       rx_data_3;
  logic [1:0] choice;
  logic       choice_valid;

  modport master (
    output key_1, key_2, key_3,
    input  rx_data_1, rx_data_2, rx_data_3, choice, choice_valid
  );

  modport slave (
    input  key_1, key_2, key_3,
    output rx_data_1, rx_data_2, rx_data_3, choice, choice_valid
  );
endinterface

// File: rtl/gesture_key_conditioner.sv
// gesture_key_conditioner
//   Input stage of the rock-paper-scissors game. Each raw active-low key is
//   synchronized (2 flops), debounced, and its debounced press (1->0) becomes
//   a one-cycle event. One event at a time is accepted (key_1 > key_2 > key_3
//   on ties) and turned into a PULSE_CYCLES-wide low pulse on its rx_data
//   line, followed by a PULSE_CYCLES guard gap during which new events are
//   discarded.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of gesture_key_conditioner_if (keys in, events out)
module gesture_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int CNT_W           = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  gesture_key_conditioner_if.slave    bus
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic [2:0] key_raw;
  logic [2:0] press_vec;

  assign key_raw = {bus.key_3, bus.key_2, bus.key_1};

  // ---------------------------------------------------------------------
  // Per-key synchronizer, debouncer and press-edge detector
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic             sync1_q, sync2_q;
      logic             stable_q, stable_d;
      logic             stable_dly_q;
      logic             press_q, press_d;
      logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

      always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == stable_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          // Mismatch has persisted long enough: adopt the new level.
          stable_d = sync2_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
        // Edge is taken on the registered stable value so the arbiter sees
        // a clean, registered one-cycle flag. Releases produce nothing.
        press_d = stable_dly_q & ~stable_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q      <= 1'b1;
          sync2_q      <= 1'b1;
          stable_q     <= 1'b1;
          stable_dly_q <= 1'b1;
          press_q      <= 1'b0;
          db_cnt_q     <= '0;
        end else begin
          sync1_q      <= key_raw[gi];
          sync2_q      <= sync1_q;
          stable_q     <= stable_d;
          stable_dly_q <= stable_q;
          press_q      <= press_d;
          db_cnt_q     <= db_cnt_d;
        end
      end

      assign press_vec[gi] = press_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Arbitration and pulse FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [2:0]       rx_q, rx_d;             // active-low, bit i = rx_data_(i+1)
  logic [1:0]       choice_q, choice_d;
  logic             choice_valid_q, choice_valid_d;

  logic [2:0]       sel_low;                // active-low mask of the winner
  logic [1:0]       sel_code;

  // Fixed priority: key_1 > key_2 > key_3; losers are simply dropped.
  always_comb begin
    sel_low  = 3'b111;
    sel_code = 2'b00;
    if (press_vec[0]) begin
      sel_low  = 3'b110;
      sel_code = 2'b01;
    end else if (press_vec[1]) begin
      sel_low  = 3'b101;
      sel_code = 2'b10;
    end else if (press_vec[2]) begin
      sel_low  = 3'b011;
      sel_code = 2'b11;
    end
  end

  always_comb begin
    state_d        = state_q;
    pulse_cnt_d    = pulse_cnt_q;
    rx_d           = rx_q;
    choice_d       = choice_q;
    choice_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|press_vec) begin
          rx_d           = sel_low;
          pulse_cnt_d    = PULSE_LAST;
          choice_d       = sel_code;
          choice_valid_d = 1'b1;
          state_d        = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q == '0) begin
          rx_d        = 3'b111;
          pulse_cnt_d = PULSE_LAST;
          state_d     = ST_GAP;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (pulse_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 1'b1;
        end
      end
      default: begin
        rx_d    = 3'b111;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pulse_cnt_q    <= '0;
      rx_q           <= 3'b111;
      choice_q       <= 2'b00;
      choice_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pulse_cnt_q    <= pulse_cnt_d;
      rx_q           <= rx_d;
      choice_q       <= choice_d;
      choice_valid_q <= choice_valid_d;
    end
  end

  assign bus.rx_data_1    = rx_q[0];
  assign bus.rx_data_2    = rx_q[1];
  assign bus.rx_data_3    = rx_q[2];
  assign bus.choice       = choice_q;
  assign bus.choice_valid = choice_valid_q;

endmodule

// File: tb/tb_gesture_key_conditioner.sv
// tb_gesture_key_conditioner
//   Directed scenarios followed by random key activity, every cycle checked
//   against a cycle-level reference model of the key conditioner.
module tb_gesture_key_conditioner;

  localparam int D = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gesture_key_conditioner_if bus ();

  gesture_key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .CNT_W          (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int       cyc = 0;
  bit [2:0] d1 = 3'b111, d2 = 3'b111;   // raw key 1 and 2 edges ago
  bit [2:0] stab = 3'b111;
  int       run [3];
  bit [2:0] pend_a = 3'b000, pend_b = 3'b000;
  int       t0 = -1000;                // edge at which last pulse started
  int       sel_m = 0;
  bit [1:0] choice_m = 2'b00;

  // Observed pulse bookkeeping
  int       fall_cnt [3];
  int       fall_at  [3];
  int       width    [3];
  bit [2:0] prev_rx = 3'b111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge of the reference model; k is what the DUT sampled.
  task automatic model_edge(input bit [2:0] k, input bit r);
    bit [2:0] syn, newp, ev;
    if (r) begin
      d1 = 3'b111; d2 = 3'b111; stab = 3'b111;
      for (int i = 0; i < 3; i++) run[i] = 0;
      pend_a = 3'b000; pend_b = 3'b000;
      t0 = -1000; choice_m = 2'b00;
    end else begin
      syn = d2; d2 = d1; d1 = k;
      newp = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (syn[i] != stab[i]) begin
          run[i]++;
          if (run[i] == D) begin
            if (stab[i]) newp[i] = 1'b1;
            stab[i] = syn[i];
            run[i]  = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      // A debounced press reaches the outputs two edges later.
      ev = pend_a; pend_a = pend_b; pend_b = newp;
      // Busy for P pulse cycles plus P gap cycles after the start edge.
      if (ev != 3'b000 && cyc >= t0 + 2*P + 1) begin
        sel_m    = ev[0] ? 0 : (ev[1] ? 1 : 2);
        t0       = cyc;
        choice_m = 2'(sel_m + 1);
      end
    end
  endtask

  task automatic step(input bit [2:0] k, input bit r);
    bit [2:0]   rx_exp;
    logic [2:0] rx_obs;
    bus.key_1 = k[0];
    bus.key_2 = k[1];
    bus.key_3 = k[2];
    rst       = r;
    @(posedge clk);
    cyc++;
    model_edge(k, r);
    #1;
    rx_exp = 3'b111;
    if (cyc - t0 < P) rx_exp[sel_m] = 1'b0;
    rx_obs = {bus.rx_data_3, bus.rx_data_2, bus.rx_data_1};
    check("rx_data_1",    rx_obs[0], rx_exp[0]);
    check("rx_data_2",    rx_obs[1], rx_exp[1]);
    check("rx_data_3",    rx_obs[2], rx_exp[2]);
    check("choice",       bus.choice, choice_m);
    check("choice_valid", bus.choice_valid, (cyc == t0));
    for (int i = 0; i < 3; i++) begin
      if (prev_rx[i] === 1'b1 && rx_obs[i] === 1'b0) begin
        fall_cnt[i]++;
        fall_at[i] = cyc;
      end
      if (prev_rx[i] === 1'b0 && rx_obs[i] === 1'b1) width[i] = cyc - fall_at[i];
      prev_rx[i] = (rx_obs[i] === 1'b0) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic hold(input int n, input bit [2:0] k);
    repeat (n) step(k, 1'b0);
  endtask

  initial begin
    int ke, f0, f1, f2, n;
    bit [2:0] kr;
    for (int i = 0; i < 3; i++) begin
      run[i] = 0; fall_cnt[i] = 0; fall_at[i] = 0; width[i] = 0;
    end

    // Reset state
    repeat (3) step(3'b111, 1'b1);
    check("reset_rx", {bus.rx_data_3, bus.rx_data_2, bus.rx_data_1}, 3'b111);
    hold(5, 3'b111);

    // 1: clean key_3 press held 50 cycles
    f0 = fall_cnt[0]; f1 = fall_cnt[1]; f2 = fall_cnt[2];
    ke = cyc + 1;
    hold(50, 3'b011);
    check("t1_latency", fall_at[2] - ke, 11);
    check("t1_width",   width[2], 4);
    check("t1_count3",  fall_cnt[2] - f2, 1);
    check("t1_count12", (fall_cnt[0] - f0) + (fall_cnt[1] - f1), 0);
    check("t1_choice",  bus.choice, 2'b11);
    hold(30, 3'b111);

    // 2: key_1 bounces every 3 cycles for 30 cycles, then settles low
    f0 = fall_cnt[0];
    for (int i = 0; i < 10; i++) hold(3, (i % 2 == 0) ? 3'b110 : 3'b111);
    check("t2_no_bounce_pulse", fall_cnt[0] - f0, 0);
    ke = cyc + 1;
    hold(40, 3'b110);
    check("t2_latency", fall_at[0] - ke, 11);
    check("t2_width",   width[0], 4);
    check("t2_count",   fall_cnt[0] - f0, 1);
    check("t2_choice",  bus.choice, 2'b01);
    hold(30, 3'b111);

    // 3: key_1 and key_2 fall together
    f0 = fall_cnt[0]; f1 = fall_cnt[1];
    hold(40, 3'b100);
    check("t3_count1",  fall_cnt[0] - f0, 1);
    check("t3_count2",  fall_cnt[1] - f1, 0);
    check("t3_choice",  bus.choice, 2'b01);
    hold(30, 3'b111);

    // 4: key_3 press lands while key_2's pulse is active
    f1 = fall_cnt[1]; f2 = fall_cnt[2];
    hold(3, 3'b101);
    hold(40, 3'b001);
    check("t4_count2", fall_cnt[1] - f1, 1);
    check("t4_count3", fall_cnt[2] - f2, 0);
    check("t4_choice", bus.choice, 2'b10);
    hold(30, 3'b111);

    // 5: three press/release cycles, then a long hold
    f2 = fall_cnt[2];
    for (int i = 0; i < 3; i++) begin
      hold(30, 3'b011);
      hold(30, 3'b111);
    end
    check("t5_three_pulses", fall_cnt[2] - f2, 3);
    check("t5_width", width[2], 4);
    f2 = fall_cnt[2];
    hold(200, 3'b011);
    check("t5_hold_one", fall_cnt[2] - f2, 1);
    hold(30, 3'b111);

    // 6: reset in the second cycle of a pulse
    n = 0;
    while (bus.rx_data_1 !== 1'b0 && n < 40) begin
      step(3'b110, 1'b0);
      n++;
    end
    check("t6_pulse_seen", bus.rx_data_1, 1'b0);
    step(3'b111, 1'b0);
    step(3'b111, 1'b1);
    check("t6_rx_after_rst", {bus.rx_data_3, bus.rx_data_2, bus.rx_data_1}, 3'b111);
    check("t6_choice_after_rst", bus.choice, 2'b00);
    check("t6_valid_after_rst",  bus.choice_valid, 1'b0);
    f0 = fall_cnt[0];
    hold(40, 3'b111);
    check("t6_no_residual", fall_cnt[0] - f0, 0);

    // Random key activity with occasional resets
    kr = 3'b111;
    repeat (3000) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 15) == 0) kr[i] = ~kr[i];
      step(kr, ($urandom_range(0, 599) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
